// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared state encoding and default constants for pc_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam int C_XLEN      = 32;
    localparam int C_BOOT_ADDR = 0;
    localparam int C_PC_INC    = 4;
    localparam int C_RAS_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack; a full push drops the oldest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            empty,
    output logic            overflow,
    output logic            underflow
);

    localparam int C_PW = $clog2(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [C_PW-1:0] r_ptr;
    logic [C_PW:0]   r_count;

    // r_ptr is the next write slot, so the top of stack sits just below it
    assign dout  = r_mem[r_ptr - C_PW'(1)];
    assign empty = (r_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_count   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (push) begin
                r_ptr <= r_ptr + C_PW'(1);
                if (r_count == (C_PW+1)'(DEPTH)) begin
                    overflow <= 1'b1;
                end else begin
                    r_count <= r_count + (C_PW+1)'(1);
                end
            end else if (pop) begin
                if (r_count == '0) begin
                    underflow <= 1'b1;
                end else begin
                    r_ptr   <= r_ptr - C_PW'(1);
                    r_count <= r_count - (C_PW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_ptr] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_seq.sv
// ============================================================================
// Module      : pc_seq
// Description : Fetch-stage PC sequencer with boot, halt and redirects.
//               Return stack built only when PC_SEQ_RAS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int              XLEN      = C_XLEN,
    parameter logic [XLEN-1:0] BOOT_ADDR = XLEN'(C_BOOT_ADDR),
    parameter logic [XLEN-1:0] PC_INC    = XLEN'(C_PC_INC),
    parameter int              RAS_DEPTH = C_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    input  logic [XLEN-1:0] ret_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [1:0]      state_o,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            w_advance;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_ret_pc;

    // A redirect only takes effect in RUN when neither halt nor stall wins
    assign w_advance = (r_state == RUN) && !halt_req && !stall;
    assign w_pop     = w_advance && ret;
    assign w_push    = w_advance && !ret && jump && call;

`ifdef PC_SEQ_RAS_EN
    logic [XLEN-1:0] w_ras_dout;
    logic            w_ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .din       (r_pc + PC_INC),
        .dout      (w_ras_dout),
        .empty     (w_ras_empty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    assign w_ret_pc = w_ras_empty ? ret_target : w_ras_dout;
`else
    logic w_unused;

    assign w_unused      = ^{w_push, w_pop, RAS_DEPTH[0]};
    assign w_ret_pc      = ret_target;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (ret) begin
                        r_pc <= w_ret_pc;
                    end else if (jump) begin
                        r_pc <= jump_target;
                    end else if (branch_taken) begin
                        r_pc <= branch_target;
                    end else begin
                        r_pc <= r_pc + PC_INC;
                    end
                end
                HALT: begin
                    if (resume) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_pc    <= BOOT_ADDR;
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign state_o  = r_state;
    assign pc_valid = (r_state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_pc_seq.sv
// ============================================================================
// Module      : tb_pc_seq
// Description : Directed self-checking bench for pc_seq against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_seq;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h400;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic        branch_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0, ret_target = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  state_o;
    logic        ras_overflow, ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    pc_seq #(
        .XLEN      (XLEN),
        .BOOT_ADDR (BOOT),
        .PC_INC    (32'd4),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .halt_req      (halt_req),
        .resume        (resume),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .ret_target    (ret_target),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .state_o       (state_o),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0=boot, 1=run, 2=halt; stack is a bounded queue
    int          m_mode = 0;
    logic [31:0] m_pc   = '0;
    logic        m_ovf  = 1'b0;
    logic        m_unf  = 1'b0;
    logic [31:0] m_stk[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0;
            m_pc   = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_stk.delete();
        end else begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
            if (m_mode == 0) begin
                m_pc   = BOOT;
                m_mode = 1;
            end else if (m_mode == 2) begin
                if (resume) m_mode = 1;
            end else if (halt_req) begin
                m_mode = 2;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (ret) begin
                if (RAS_EN && m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_pc  = ret_target;
                    m_unf = RAS_EN;
                end
            end else if (jump) begin
                if (call && RAS_EN) begin
                    m_stk.push_back(m_pc + 32'd4);
                    if (m_stk.size() > DEPTH) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                m_pc = jump_target;
            end else if (branch_taken) begin
                m_pc = branch_target;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model.pc", pc, m_pc);
        check("model.valid", {31'd0, pc_valid}, {31'd0, m_mode == 1});
        check("model.state", {30'd0, state_o}, m_mode);
        check("model.ovf", {31'd0, ras_overflow}, {31'd0, m_ovf});
        check("model.unf", {31'd0, ras_underflow}, {31'd0, m_unf});
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        stall = 0; halt_req = 0; resume = 0;
        branch_taken = 0; jump = 0; call = 0; ret = 0;
    endtask

    logic [31:0] call_tgt [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
`ifdef PC_SEQ_RAS_EN
    logic [31:0] ret_exp [5] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004, 32'hAA};
`else
    logic [31:0] ret_exp [5] = '{32'hAA, 32'hAA, 32'hAA, 32'hAA, 32'hAA};
`endif

    initial begin
        #1;
        check("reset.pc", pc, 32'h0);
        check("reset.valid", {31'd0, pc_valid}, 32'd0);
        check("reset.state", {30'd0, state_o}, 32'd0);
        #11 reset = 0;
        check("boot.pc_before_edge", pc, 32'h0);
        tick; check("boot.pc0", pc, 32'h400); check("boot.valid", {31'd0, pc_valid}, 32'd1);
        tick; check("boot.pc1", pc, 32'h404);
        tick; check("boot.pc2", pc, 32'h408);

        stall = 1; branch_taken = 1; branch_target = 32'h999;
        tick; check("prio.stall", pc, 32'h408);
        idle; ret = 1; jump = 1; jump_target = 32'h300; ret_target = 32'h80;
        tick; check("prio.ret_jump", pc, 32'h80);
`ifdef PC_SEQ_RAS_EN
        check("prio.underflow", {31'd0, ras_underflow}, 32'd1);
`endif
        idle; jump = 1; jump_target = 32'h100;
        tick; check("call.setup", pc, 32'h100);
        call = 1; jump_target = 32'h200;
        tick; check("call.jump", pc, 32'h200);
        idle; ret = 1; ret_target = 32'h55;
        tick;
`ifdef PC_SEQ_RAS_EN
        check("call.ret", pc, 32'h104);
`else
        check("call.ret", pc, 32'h55);
`endif
        idle; jump = 1; call = 1;
        for (int i = 0; i < 5; i++) begin
            jump_target = call_tgt[i];
            tick; check("ovf.call_pc", pc, call_tgt[i]);
        end
`ifdef PC_SEQ_RAS_EN
        check("ovf.pulse", {31'd0, ras_overflow}, 32'd1);
`endif
        idle; ret = 1; ret_target = 32'hAA;
        for (int i = 0; i < 5; i++) begin
            tick; check("ovf.ret_pc", pc, ret_exp[i]);
        end

        idle; jump = 1; jump_target = 32'h10;
        tick; idle; halt_req = 1;
        tick; check("halt.pc", pc, 32'h10); check("halt.valid", {31'd0, pc_valid}, 32'd0);
        tick; check("halt.state", {30'd0, state_o}, 32'd2);
        idle; resume = 1;
        tick; check("resume.pc", pc, 32'h10); check("resume.valid", {31'd0, pc_valid}, 32'd1);
        idle;
        tick; check("resume.next", pc, 32'h14);

        jump = 1; jump_target = 32'hFFFF_FFFC;
        tick; idle;
        tick; check("wrap.pc", pc, 32'h0);
        call = 1;
        tick; check("call_no_jump", pc, 32'h4);
        idle; branch_taken = 1; branch_target = 32'h700;
        tick; check("branch.pc", pc, 32'h700);

        idle; jump = 1; call = 1; jump_target = 32'h800;
        tick; idle;
        #1 reset = 1;
        #1;
        check("areset.pc", pc, 32'h0);
        check("areset.state", {30'd0, state_o}, 32'd0);
        tick;
        reset = 0;
        tick; check("areset.boot", pc, 32'h400);
        ret = 1; ret_target = 32'h66;
        tick; check("areset.ret", pc, 32'h66);
`ifdef PC_SEQ_RAS_EN
        check("areset.underflow", {31'd0, ras_underflow}, 32'd1);
`endif
        idle;
        tick; tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the MIPS fetch stage, replacing the fixed-increment PC. After reset it runs a boot sequence to a configurable start address, then advances by a configurable increment, with stall, halt/resume and redirect inputs (branch, jump, call, return). An optional return-address stack supplies return targets. The output `pc` drives instruction-memory address generation.

## Interface
- `XLEN`, 32: PC width in bits.
- `BOOT_ADDR`, 0: first fetch address after reset.
- `PC_INC`, 4: sequential increment.
- `RAS_DEPTH`, 4: return-stack entries; power of two, at least 2.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  hold PC this cycle.
- `halt_req`  in  1  enter HALT.
- `resume`  in  1  leave HALT.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  XLEN  branch destination.
- `jump`  in  1  redirect to `jump_target`.
- `jump_target`  in  XLEN  jump destination.
- `call`  in  1  qualifies `jump` as a call; push return address.
- `ret`  in  1  return redirect.
- `ret_target`  in  XLEN  return destination when no stack entry is available.
- `pc`  out  XLEN  current fetch address.
- `pc_valid`  out  1  `pc` is fetchable this cycle.
- `state_o`  out  2  FSM state.
- `ras_overflow`  out  1  one-cycle pulse: push overwrote the oldest entry.
- `ras_underflow`  out  1  one-cycle pulse: pop while the stack was empty.

## Operation
- States (2-bit): BOOT=00, RUN=01, HALT=10; 11 unused and treated as BOOT.
- Reset state: state BOOT, `pc`=0, `pc_valid`=0, stack empty, both pulse outputs 0.
- **BOOT:** on the next edge, `pc`←BOOT_ADDR and state→RUN. All other inputs are ignored in BOOT.
- **RUN:** `pc_valid`=1. Each edge applies the first matching rule in this priority order:
  1. `halt_req`: state→HALT, `pc` held.
  2. `stall`: `pc` held; redirects this cycle are dropped. The caller must re-present them.
  3. `ret`: `pc`←top of stack (pop); on an empty stack or with the stack compiled out, `pc`←`ret_target`.
  4. `jump`: `pc`←`jump_target`; if `call`, also push `pc`+PC_INC.
  5. `branch_taken`: `pc`←`branch_target`.
  6. Otherwise `pc`←`pc`+PC_INC.
- **HALT:** `pc_valid`=0 and `pc` held. `resume` → RUN, with `pc` unchanged, so fetch restarts at the held address. `halt_req` is ignored while in HALT.
- `call` without `jump` has no effect.
- `ret` together with `jump` (or `call`): `ret` wins, with no push.
- Arithmetic is modulo 2^XLEN: `pc`+PC_INC wraps, for example 0xFFFF_FFFC+4 → 0 at XLEN=32.
- Targets are used unmodified; there is no alignment masking.
- Stack: circular buffer with a pointer and a count.
  - Push when full overwrites the oldest entry and pulses `ras_overflow`; the count stays at RAS_DEPTH.
  - Pop when empty pulses `ras_underflow` and the count stays 0.

## Timing
- Single-cycle: a redirect sampled at edge N is visible on `pc` after edge N.
- The first valid `pc` (BOOT_ADDR) appears after the first edge following reset deassertion.
- `state_o` and `pc_valid` are registered-state outputs; `pc_valid` decodes combinationally from state.
- Asserting `reset` mid-operation immediately clears `pc`, the state and the stack, with no clock needed.

## Configuration
- Macro `PC_SEQ_RAS_EN`.
  - Defined: the return stack is built; `ret` pops it.
  - Undefined: no stack storage; `ret` always uses `ret_target`; `call` only jumps; `ras_overflow` and `ras_underflow` are tied to 0.

## Structure
- Package `pc_seq_pkg`: the state enum and its encodings (BOOT, RUN, HALT) and the default parameter constants.
- Sub-module `pc_ras` (push, pop, data in, data out, empty, overflow, underflow) is instantiated only under `PC_SEQ_RAS_EN`.

## Test plan
- **Reset and boot:** BOOT_ADDR=0x400, release reset → `pc`=0, invalid for one edge; then 0x400, 0x404, 0x408, valid.
- **Priority:** `stall`+`branch_taken` → `pc` held. Next cycle, `ret`+`jump` with an empty stack and `ret_target`=0x80 → `pc`=0x80 and `ras_underflow` pulses.
- **Call/return:** at `pc`=0x100, `jump`+`call` to 0x200 → `pc`=0x200. Then `ret` → `pc`=0x104.
- **Stack overflow:** RAS_DEPTH=4, five nested calls → `ras_overflow` pulses on the 5th. Five returns give the last four return addresses, then underflow on the 5th.
- **Halt/resume and wrap:** halt at 0x10 → `pc_valid`=0 and `pc` stays 0x10; `resume` → 0x10 then 0x14. Separately, jump to 0xFFFF_FFFC → next `pc`=0.
- **Async reset mid-run:** reset asserted between edges → `pc`=0 and state BOOT immediately; the stack is empty afterwards (a `ret` underflows).
